// File: rtl/alu_pkg.sv
// alu_pkg: definitions shared across the ALU execute-stage blocks.
//   div_state_t   : divider FSM states (IDLE=0, PREP=1, ITER=2, FIX=3)
//   DIV_WIDTH     : default datapath width of the divider
//   DIV_LATENCY   : start-to-done latency of a full iterative divide
//   DIV_ZERO_QUOT : quotient returned for a zero divisor (all ones)
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    ITER = 2'd2,
    FIX  = 2'd3
  } div_state_t;

  localparam int unsigned DIV_WIDTH   = 32;
  localparam int unsigned DIV_LATENCY = DIV_WIDTH + 2;

  localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOT = '1;

  // Latency of a full iterative divide for an arbitrary width.
  function automatic int unsigned div_latency(input int unsigned width);
    return width + 2;
  endfunction

endpackage

// File: rtl/alu_div_step.sv
// alu_div_step: one combinational radix-2 restoring division step.
//   rem      [WIDTH-1:0] in  : partial remainder
//   quo      [WIDTH-1:0] in  : quotient / remaining dividend bits
//   dvs_mag  [WIDTH-1:0] in  : divisor magnitude
//   rem_next [WIDTH-1:0] out : partial remainder after this step
//   quo_next [WIDTH-1:0] out : quotient after this step (new bit in LSB)
module alu_div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] dvs_mag,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] trial;
  logic           fits;

  // Shifted remainder can reach WIDTH+1 bits; the subtraction is done at
  // that width so its top bit is a true borrow.
  assign rem_sh   = {rem, quo[WIDTH-1]};
  assign trial    = rem_sh - {1'b0, dvs_mag};
  assign fits     = ~trial[WIDTH];
  assign rem_next = fits ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
  assign quo_next = {quo[WIDTH-2:0], fits};

endmodule

// File: rtl/alu_or_reduce.sv
// alu_or_reduce: ALU OR-reduction block.
//   operand [WIDTH-1:0] in  : value to reduce
//   result              out : 1 when any operand bit is set
module alu_or_reduce #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] operand,
  output logic             result
);

  assign result = |operand;

endmodule

// File: rtl/alu_divider.sv
// alu_divider: multi-cycle DIV/DIVU unit for the ALU execute stage.
// Radix-2 restoring, one quotient bit per cycle; zero divisors take a
// fast path to a one-cycle done.
//   clk, rst    : rising-edge clock, asynchronous active-high reset
//   start       : request, sampled only when idle
//   is_signed   : 1 = DIV, 0 = DIVU (latched with start)
//   dividend    : latched with start
//   divisor     : latched with start
//   flush       : synchronous abort, wins over start
//   busy        : operation in progress
//   done        : one-cycle pulse, results valid
//   quotient    : registered result, held until next done
//   remainder   : registered result, held until next done
//   div_by_zero : registered flag, held until next done
// Optional build macro ALU_DIV_EARLY_OUT_EN: skip iteration when
// |dividend| < |divisor|.
module alu_divider
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  div_state_t       state_q, state_d;
  logic [WIDTH-1:0] dvd_q, dvs_q, rem_q, quo_q;
  logic             sgn_q, sign_q_q, sign_r_q, dz_q;
  logic [CNT_W-1:0] cnt_q;

  logic             divisor_nz;
  logic [WIDTH-1:0] dvd_mag, dvs_mag;
  logic [WIDTH-1:0] step_rem, step_quo;
  logic             last_iter;

  alu_or_reduce #(.WIDTH(WIDTH)) u_or_reduce (
    .operand (divisor),
    .result  (divisor_nz)
  );

  alu_div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .dvs_mag  (dvs_q),
    .rem_next (step_rem),
    .quo_next (step_quo)
  );

  assign dvd_mag   = (sgn_q && dvd_q[WIDTH-1]) ? (~dvd_q + WIDTH'(1)) : dvd_q;
  assign dvs_mag   = (sgn_q && dvs_q[WIDTH-1]) ? (~dvs_q + WIDTH'(1)) : dvs_q;
  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));
  assign busy      = (state_q != IDLE);

`ifdef ALU_DIV_EARLY_OUT_EN
  logic early_out;
  assign early_out = (dvd_mag < dvs_mag);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start && !flush) begin
          state_d = divisor_nz ? PREP : FIX;
        end
      end
      PREP: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
`ifdef ALU_DIV_EARLY_OUT_EN
          state_d = early_out ? FIX : ITER;
`else
          state_d = ITER;
`endif
        end
      end
      ITER: begin
        if (flush) begin
          state_d = IDLE;
        end else if (last_iter) begin
          state_d = FIX;
        end
      end
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FIX always applies the sign corrections; the zero-divisor and
  // early-out paths preload their final values with both signs cleared
  // so FIX passes them through unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      sgn_q       <= 1'b0;
      sign_q_q    <= 1'b0;
      sign_r_q    <= 1'b0;
      dz_q        <= 1'b0;
      cnt_q       <= '0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start && !flush) begin
            dvd_q <= dividend;
            dvs_q <= divisor;
            sgn_q <= is_signed;
            if (!divisor_nz) begin
              quo_q    <= '1;
              rem_q    <= dividend;
              sign_q_q <= 1'b0;
              sign_r_q <= 1'b0;
              dz_q     <= 1'b1;
            end else begin
              dz_q <= 1'b0;
            end
          end
        end
        PREP: begin
          if (!flush) begin
            dvs_q    <= dvs_mag;
            sign_q_q <= sgn_q & (dvd_q[WIDTH-1] ^ dvs_q[WIDTH-1]);
            sign_r_q <= sgn_q & dvd_q[WIDTH-1];
            cnt_q    <= '0;
`ifdef ALU_DIV_EARLY_OUT_EN
            if (early_out) begin
              quo_q    <= '0;
              rem_q    <= dvd_q;
              sign_q_q <= 1'b0;
              sign_r_q <= 1'b0;
            end else begin
              quo_q <= dvd_mag;
              rem_q <= '0;
            end
`else
            quo_q <= dvd_mag;
            rem_q <= '0;
`endif
          end
        end
        ITER: begin
          if (!flush) begin
            rem_q <= step_rem;
            quo_q <= step_quo;
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        FIX: begin
          quotient    <= sign_q_q ? (~quo_q + WIDTH'(1)) : quo_q;
          remainder   <= sign_r_q ? (~rem_q + WIDTH'(1)) : rem_q;
          div_by_zero <= dz_q;
          done        <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_divider.sv
module tb_alu_divider;

  logic        clk;
  logic        rst;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int checks   = 0;
  int failures = 0;

  alu_divider #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .flush       (flush),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain integer division, truncating toward zero; results
  // taken modulo 2^32 so MIN / -1 wraps naturally.
  function automatic void model(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r, output logic dz);
    longint sa, sb;
    if (b == 32'd0) begin
      q  = 32'hFFFF_FFFF;
      r  = a;
      dz = 1'b1;
    end else begin
      if (sgn) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
      end else begin
        sa = longint'({32'd0, a});
        sb = longint'({32'd0, b});
      end
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
      dz = 1'b0;
    end
  endfunction

  function automatic int exp_lat(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint ma, mb;
    if (b == 32'd0) return 1;
    ma = sgn ? longint'($signed(a)) : longint'({32'd0, a});
    mb = sgn ? longint'($signed(b)) : longint'({32'd0, b});
    if (ma < 0) ma = -ma;
    if (mb < 0) mb = -mb;
`ifdef ALU_DIV_EARLY_OUT_EN
    if (ma < mb) return 2;
`endif
    return 34;
  endfunction

  // Called at #1 after an edge; counts edges until done (bounded).
  task automatic wait_done(input int limit, output int n, output bit seen, output bit busy_bad);
    n        = 0;
    seen     = 1'b0;
    busy_bad = 1'b0;
    while (!seen && n < limit) begin
      @(posedge clk);
      #1;
      n++;
      if (done) seen = 1'b1;
      else if (!busy) busy_bad = 1'b1;
    end
  endtask

  task automatic do_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eq, input logic [31:0] er, input logic edz,
                       input string tag);
    int n;
    bit seen, busy_bad;
    start     = 1'b1;
    is_signed = sgn;
    dividend  = a;
    divisor   = b;
    @(posedge clk);
    #1;
    start     = 1'b0;
    is_signed = ~sgn;
    dividend  = $urandom;
    divisor   = $urandom;
    chk({tag, "_busy_e0"}, 32'(busy), 32'd1);
    wait_done(100, n, seen, busy_bad);
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      chk({tag, "_latency"}, 32'(n), 32'(exp_lat(sgn, a, b)));
      chk({tag, "_quot"}, quotient, eq);
      chk({tag, "_rem"}, remainder, er);
      chk({tag, "_dz"}, 32'(div_by_zero), 32'(edz));
      chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    end
    chk({tag, "_busy_held"}, 32'(busy_bad), 32'd0);
  endtask

  task automatic count_done(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (done) cnt++;
    end
  endtask

  initial begin
    logic [31:0] pq, pr, eq, er, ra, rb;
    logic        pdz, edz, rs;
    int          n, cnt;
    bit          seen, busy_bad;

    vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
    vecs[1]  = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0};
    vecs[2]  = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0};
    vecs[3]  = '{1'b0, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  32'h1234_5678,  1'b1};
    vecs[4]  = '{1'b1, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  32'h1234_5678,  1'b1};
    vecs[5]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0};
    vecs[6]  = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  1'b0};
    vecs[7]  = '{1'b0, 32'd3,          32'd10,         32'd0,          32'd3,          1'b0};
    vecs[8]  = '{1'b1, 32'hFFFF_FFFD,  32'd10,         32'd0,          32'hFFFF_FFFD,  1'b0};
    vecs[9]  = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0};
    vecs[10] = '{1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0};
    vecs[11] = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0};
    vecs[12] = '{1'b1, 32'h8000_0000,  32'd0,          32'hFFFF_FFFF,  32'h8000_0000,  1'b1};
    vecs[13] = '{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE,  1'b0};

    rst       = 1'b1;
    start     = 1'b0;
    is_signed = 1'b0;
    dividend  = '0;
    divisor   = '0;
    flush     = 1'b0;
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_quot", quotient, 32'd0);
    chk("reset_rem", remainder, 32'd0);
    chk("reset_dz", 32'(div_by_zero), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Table vectors
    for (int i = 0; i < 14; i++) begin
      do_op(vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dz,
            $sformatf("vec%0d", i));
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_done_pulse", i), 32'(done), 32'd0);
    end

    // Back-to-back: second start presented while done is high
    do_op(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, "b2b_first");
    chk("b2b_done_high", 32'(done), 32'd1);
    do_op(1'b0, 32'd20, 32'd3, 32'd6, 32'd2, 1'b0, "b2b_second");
    @(posedge clk);
    #1;

    // start during an operation is ignored
    start = 1'b1; is_signed = 1'b0; dividend = 32'd1000; divisor = 32'd10;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    start = 1'b1; dividend = 32'd9; divisor = 32'd0;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(100, n, seen, busy_bad);
    chk("ignore_start_seen", 32'(seen), 32'd1);
    chk("ignore_start_latency", 32'(n), 32'd28);
    chk("ignore_start_quot", quotient, 32'd100);
    chk("ignore_start_dz", 32'(div_by_zero), 32'd0);
    @(posedge clk);
    #1;

    // Flush mid-iteration: no done, outputs hold
    pq = quotient; pr = remainder; pdz = div_by_zero;
    start = 1'b1; is_signed = 1'b0; dividend = 32'd50; divisor = 32'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush_busy_low", 32'(busy), 32'd0);
    chk("flush_no_done_now", 32'(done), 32'd0);
    count_done(40, cnt);
    chk("flush_no_done_later", 32'(cnt), 32'd0);
    chk("flush_quot_hold", quotient, pq);
    chk("flush_rem_hold", remainder, pr);
    chk("flush_dz_hold", 32'(div_by_zero), 32'(pdz));
    do_op(1'b0, 32'd20, 32'd3, 32'd6, 32'd2, 1'b0, "after_flush");
    @(posedge clk);
    #1;

    // flush beats start in IDLE
    flush = 1'b1; start = 1'b1; dividend = 32'd9; divisor = 32'd4;
    @(posedge clk);
    #1;
    flush = 1'b0; start = 1'b0;
    chk("flush_vs_start_busy", 32'(busy), 32'd0);
    count_done(40, cnt);
    chk("flush_vs_start_no_done", 32'(cnt), 32'd0);

    // flush during FIX does not suppress done
    start = 1'b1; is_signed = 1'b0; dividend = 32'd100; divisor = 32'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (33) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush_in_fix_done", 32'(done), 32'd1);
    chk("flush_in_fix_quot", quotient, 32'd14);
    @(posedge clk);
    #1;

    // Zero-divisor result, then asynchronous reset mid-iteration
    do_op(1'b0, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1, "dz_before_rst");
    @(posedge clk);
    #1;
    start = 1'b1; is_signed = 1'b1; dividend = 32'd1000; divisor = 32'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_done", 32'(done), 32'd0);
    chk("async_rst_quot", quotient, 32'd0);
    chk("async_rst_rem", remainder, 32'd0);
    chk("async_rst_dz", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    count_done(40, cnt);
    chk("async_rst_no_done", 32'(cnt), 32'd0);

    // Randomized operations against the reference model
    for (int i = 0; i < 150; i++) begin
      rs = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 9))
        0:       begin ra = $urandom; rb = 32'd0; end
        1:       begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2, 3:    begin ra = 32'($urandom_range(0, 200)); rb = 32'($urandom_range(1, 20)); end
        4:       begin ra = $urandom; rb = 32'($urandom_range(1, 3)) ^ {32{rs}}; end
        default: begin ra = $urandom; rb = $urandom >> $urandom_range(0, 31); end
      endcase
      model(rs, ra, rb, eq, er, edz);
      do_op(rs, ra, rb, eq, er, edz, $sformatf("rand%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_divider.md
Name: alu_divider

Overview:
- Multi-cycle 32-bit integer divider in the ALU execute stage; handles DIV/DIVU.
- Uses radix-2 restoring iteration, one quotient bit per cycle.
- Feeds its divisor to the ALU's OR-reduction block for zero detection, and consumes that block's single-bit output to take a divide-by-zero fast path.
- The pipeline stalls on busy and captures results on done.

Parameters:
WIDTH, 32, operand/result width in bits; WIDTH >= 2.

Ports:
clk  input  1  clock, rising-edge
rst  input  1  reset, asynchronous, active-high
start  input  1  request; sampled only in IDLE
is_signed  input  1  1 = signed (DIV), 0 = unsigned (DIVU); latched with start
dividend  input  WIDTH  latched with start
divisor  input  WIDTH  latched with start
flush  input  1  synchronous abort from pipeline flush
busy  output  1  operation in progress
done  output  1  one-cycle pulse; results valid
quotient  output  WIDTH  registered result
remainder  output  WIDTH  registered result
div_by_zero  output  1  registered; valid with done, held until next done

Behaviour:
- Reset (async, active-high):
  - State goes to IDLE.
  - busy, done, quotient, remainder, div_by_zero and internal counter all go to 0.
  - Reset mid-operation discards the operation; no done follows.
- States: IDLE, PREP, ITER, FIX.
- Edge E0 (the edge that accepts start):
  - Accepted only in IDLE; start in any other state is ignored.
  - Operands and is_signed are latched.
  - zero = NOT(OR-reduction of divisor).
  - If zero: next state FIX, with the div-zero flag set.
  - Otherwise: next state PREP.
  - busy goes to 1.
- PREP:
  - Forms magnitudes: two's-complement absolute value when is_signed and MSB=1, else raw.
  - Records sign_q = sign(dividend) XOR sign(divisor) and sign_r = sign(dividend); both are 0 if unsigned.
  - Clears partial remainder; counter <= 0; next state ITER.
- ITER, per edge:
  - {rem,quo} shift left 1.
  - trial = rem - |divisor| computed WIDTH+1 wide.
  - If non-negative: rem <= trial and quo LSB <= 1.
  - After WIDTH edges (counter = WIDTH-1): next state FIX.
- FIX:
  - Negates quotient if sign_q and remainder if sign_r.
  - Registers outputs; done <= 1 for one cycle; busy <= 0; next state IDLE.
- Latency, counted from E0:
  - Normal: done set at edge WIDTH+2 (34 for WIDTH=32).
  - Divide-by-zero: done set at edge 1.
- Divide by zero result: quotient = all ones, remainder = dividend, div_by_zero = 1. Same in both signed and unsigned modes.
- Signed MIN/-1: quotient wraps to MIN (0x80000000), remainder 0; no trap.
- Output hold:
  - quotient, remainder and div_by_zero hold until the next done.
  - div_by_zero clears on a normal done.
- Back-to-back: start may be asserted in the cycle done is high (state is IDLE) and is accepted.
- Flush:
  - Any non-IDLE state returns to IDLE at the next edge; busy <= 0; no done; outputs unchanged.
  - flush has priority over start in the same cycle.
- done and flush never coincide: FIX transitions with done regardless of flush, and flush only blocks future done.

Optional Feature:
ALU_DIV_EARLY_OUT_EN
- Defined: in PREP, if |dividend| < |divisor| (unsigned compare of magnitudes), skip ITER.
  - quotient <= 0, remainder <= dividend (original signed value); div_by_zero <= 0.
  - Proceeds to FIX with quotient and remainder negation disabled; done is set at edge 2.
- Undefined: always iterates; latency fixed at WIDTH+2.

Decomposition:
- Shared package alu_pkg holds:
  - state encoding constants (IDLE=2'd0, PREP=2'd1, ITER=2'd2, FIX=2'd3);
  - DIV_LATENCY = WIDTH+2;
  - DIV_ZERO_QUOT = all ones.
- One sub-module: alu_div_step, combinational single restoring iteration.
  - Inputs: rem, quo, divisor magnitude.
  - Outputs: next rem, next quo.
- Divisor-zero detection instantiates the existing ALU OR-reduction block; no new logic for it.

Test Plan:
- Unsigned 100 / 7, start one cycle → done exactly 34 edges after E0; quotient=14, remainder=2, div_by_zero=0; busy high edges 1..33.
- Signed -7 / 2 (0xFFFFFFF9 / 0x00000002) → quotient=0xFFFFFFFD, remainder=0xFFFFFFFF; signed 7 / -2 → quotient=0xFFFFFFFD, remainder=1.
- 0x12345678 / 0 (either mode) → done at edge 1; quotient=0xFFFFFFFF, remainder=0x12345678, div_by_zero=1; next normal op clears div_by_zero.
- Signed 0x80000000 / 0xFFFFFFFF → quotient=0x80000000, remainder=0; unsigned same operands → quotient=0, remainder=0x80000000.
- Flush at edge 10 of 50/5 → busy low at edge 11, no done ever, outputs keep prior values; new start 20/3 → quotient=6, remainder=2 after 34 edges.
- rst asserted asynchronously mid-ITER → all outputs 0 immediately, no done. Back-to-back: start held in the done cycle → second result 34 edges later.
- With ALU_DIV_EARLY_OUT_EN: 3 / 10 → done at edge 2, quotient=0, remainder=3; signed -3 / 10 → quotient=0, remainder=0xFFFFFFFD.
